// File: rtl/mac_neuron_pe.sv
// mac_neuron_pe: pipelined signed multiply-accumulate neuron with bias, saturation, ReLU and xin pass-through.
module mac_neuron_pe #(
    parameter int DW   = 8,
    parameter int ACCW = 20,
    parameter int N    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   xin,
    input  logic [DW-1:0]   w,
    input  logic [ACCW-1:0] bias,
    input  logic            relu_en,
    output logic [DW-1:0]   xout,
    output logic            xout_valid,
    output logic [ACCW-1:0] result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            ovf
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [2*DW-1:0] r_p, w_prod;
    logic r_s1_valid, r_s1_first, r_ovf_acc;
    logic [ACCW-1:0] r_bias, r_acc, w_base, w_sat;
    logic [ACCW:0] w_sum;
    logic w_accept, w_last, w_clamp, w_ovf_nx;
    assign in_ready = r_state == ACC;
    assign w_accept = in_valid && in_ready;
    assign w_last   = r_cnt == CW'(N - 1);
    assign w_prod   = $signed({{DW{xin[DW-1]}}, xin}) * $signed({{DW{w[DW-1]}}, w});
    // first term of a dot product starts from the sampled bias instead of the stale accumulator
    assign w_base   = r_s1_first ? r_bias : r_acc;
    assign w_sum    = {w_base[ACCW-1], w_base} + {{(ACCW + 1 - 2*DW){r_p[2*DW-1]}}, r_p};
    assign w_clamp  = w_sum[ACCW] != w_sum[ACCW-1];
    assign w_sat    = !w_clamp ? w_sum[ACCW-1:0] :
                      w_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    assign w_ovf_nx = (!r_s1_first && r_ovf_acc) || w_clamp;
    always_ff @(posedge clk) begin
        if (rst) r_state <= ACC;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ACC:     if (w_accept && w_last) w_next = DRAIN;
            DRAIN:   w_next = HOLD;
            HOLD:    if (out_valid && out_ready) w_next = ACC;
            default: w_next = ACC;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_bias     <= '0;
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            xout       <= '0;
            xout_valid <= 1'b0;
            result     <= '0;
            out_valid  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_first <= w_accept && r_cnt == '0;
            xout_valid <= w_accept;
            if (w_accept) begin
                r_p   <= w_prod;
                xout  <= xin;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (r_cnt == '0) r_bias <= bias;
            end
            if (r_s1_valid) begin
                r_acc     <= w_sat;
                r_ovf_acc <= w_ovf_nx;
            end
            if (r_state == DRAIN) begin
                result    <= (relu_en && w_sat[ACCW-1]) ? '0 : w_sat;
                ovf       <= w_ovf_nx;
                out_valid <= 1'b1;
            end else if (r_state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_neuron_pe.sv
// tb_mac_neuron_pe: scoreboard bench for mac_neuron_pe with an arithmetic reference model.
module tb_mac_neuron_pe;
    localparam int DW = 8, ACCW = 20, N = 4;
    localparam longint MAXV = (longint'(1) <<< (ACCW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACCW - 1));
    logic clk = 0, rst = 1, in_valid = 0, relu_en = 0, out_ready = 1;
    logic in_ready, xout_valid, out_valid, ovf;
    logic [DW-1:0] xin = 0, w = 0, xout;
    logic [ACCW-1:0] bias = 0, result;
    int n_chk = 0, n_pass = 0, cyc = 0;
    bit rnd = 0;
    logic [ACCW:0] exp_q[$];
    logic signed [DW-1:0] tx[N], tw[N];

    mac_neuron_pe #(.DW(DW), .ACCW(ACCW), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .xin(xin), .w(w),
        .bias(bias), .relu_en(relu_en), .xout(xout), .xout_valid(xout_valid), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 60) begin
            step();
            t++;
        end
        chk("in_ready_wait", in_ready, 1);
    endtask

    task automatic send_terms(int n, int gmin, int gmax, logic [ACCW-1:0] b, bit relu);
        for (int i = 0; i < n; i++) begin
            wait_ready();
            if (i == 0) begin
                bias = b;
                relu_en = relu;
            end
            in_valid = 1;
            xin = tx[i];
            w = tw[i];
            step();
            in_valid = 0;
            bias = ACCW'($urandom);
            xin = DW'($urandom);
            w = DW'($urandom);
            repeat ($urandom_range(gmax, gmin)) step();
        end
    endtask

    task automatic send_dot(bit relu, int gmin, int gmax, logic [ACCW-1:0] b);
        longint acc = longint'($signed(b));
        bit o = 0;
        for (int i = 0; i < N; i++) begin
            acc = acc + longint'(tx[i]) * longint'(tw[i]);
            if (acc > MAXV) begin acc = MAXV; o = 1; end
            else if (acc < MINV) begin acc = MINV; o = 1; end
        end
        if (relu && acc < 0) acc = 0;
        exp_q.push_back({o, ACCW'(acc)});
        send_terms(N, gmin, gmax, b, relu);
    endtask

    task automatic set_all(int x, int y);
        for (int i = 0; i < N; i++) begin
            tx[i] = DW'(x);
            tw[i] = DW'(y);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            step();
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // monitor: scoreboard pops on result handshake; pass-through and latency tracked per cycle
    logic [DW-1:0] m_x = 0;
    bit m_xv = 0, m_seen = 0, m_prev_ov = 0;
    int m_cnt = 0, t_last = 0;
    always @(negedge clk) begin
        bit a;
        logic [ACCW:0] e;
        if (m_seen) begin
            chk("xout_valid", xout_valid, m_xv);
            chk("xout", xout, m_x);
            if (out_valid && !m_prev_ov) chk("latency", cyc - t_last, 2);
            if (out_valid && out_ready && !rst) begin
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("result", $signed(result), $signed(e[ACCW-1:0]));
                    chk("ovf", ovf, e[ACCW]);
                end
            end
        end
        a = in_valid && in_ready && !rst;
        if (rst) begin
            m_seen = 1;
            m_xv = 0;
            m_x = 0;
            m_cnt = 0;
        end else begin
            m_xv = a;
            if (a) m_x = xin;
        end
        if (a) begin
            m_cnt++;
            if (m_cnt == N) begin
                m_cnt = 0;
                t_last = cyc;
            end
        end
        m_prev_ov = rst ? 0 : out_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        rst = 0;
        chk("rst_result", result, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_xout", xout, 0);
        chk("rst_xout_valid", xout_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        set_all(3, 2);
        send_dot(0, 0, 0, 0);
        set_all(-1, 10);
        send_dot(0, 0, 0, 0);
        send_dot(1, 0, 0, 0);
        set_all(5, 5);
        send_dot(1, 0, 0, -20'sd100);
        set_all(127, 127);
        send_dot(0, 0, 0, 20'd524000);
        set_all(1, 1);
        send_dot(0, 0, 0, 0);
        set_all(3, 2);
        send_dot(0, 2, 2, 0);
        drain();
        out_ready = 0;
        set_all(3, 2);
        send_dot(0, 0, 0, 0);
        begin
            int t = 0;
            while (!out_valid && t < 20) begin
                step();
                t++;
            end
        end
        chk("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            xin = DW'($urandom);
            w = DW'($urandom);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", $signed(result), 24);
            step();
        end
        in_valid = 0;
        out_ready = 1;
        step();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        drain();
        set_all(7, 9);
        send_terms(2, 0, 0, 5, 0);
        rst = 1;
        in_valid = 1;
        xin = 8'd55;
        step();
        rst = 0;
        in_valid = 0;
        chk("mid_rst_result", result, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_xout", xout, 0);
        chk("mid_rst_xout_valid", xout_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        set_all(2, 2);
        send_dot(0, 0, 0, 0);
        drain();
        rnd = 1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                tx[i] = DW'($urandom);
                tw[i] = DW'($urandom);
            end
            send_dot(1'($urandom), 0, 2, ACCW'($urandom));
        end
        rnd = 0;
        out_ready = 1;
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
